// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud generator: the rate table, the custom-rate
// select code and the phase-increment calculation used to build the increment table.
package baud_pkg;

    localparam logic [2:0] SEL_CUSTOM = 3'd7;
    localparam int         N_RATES    = 7;

    localparam int unsigned RATE_TABLE [0:N_RATES-1] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 14400
    };

    // round(baud * osr * 2^acc_w / clk_hz), done as (2*num + den) / (2*den)
    function automatic logic [63:0] calc_inc(input logic [63:0] baud,
                                             input logic [63:0] osr,
                                             input logic [63:0] acc_w,
                                             input logic [63:0] clk_hz);
        logic [63:0] num;
        num = (baud * osr) << acc_w;
        return ((num << 1) + clk_hz) / (clk_hz << 1);
    endfunction

endpackage

// File: rtl/baud_nco.sv
// Phase accumulator: adds inc every enabled clock, exposes the wrap carry combinationally
// so the caller can register it as a tick in the same cycle the phase wraps.
module baud_nco #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] inc,
    output logic             carry
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, inc};
    assign carry = sum[ACC_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: rate select / custom increment mux, phase restart detection,
// oversample counter and registered oversample and bit ticks.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int CLK_HZ = 7372800,
    parameter int ACC_W  = 24,
    parameter int OSR    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       sel,
    input  logic             cfg_wr,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             resync,
    output logic             tick_os,
    output logic             tick_bit,
    output logic [2:0]       active_sel,
    output logic             rate_err
);

    localparam int               OS_W      = $clog2(OSR);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OSR - 1);
    localparam logic [63:0]      INC0_FULL = calc_inc(64'(RATE_TABLE[0]), 64'(OSR),
                                                      64'(ACC_W), 64'(CLK_HZ));
    localparam logic [ACC_W-1:0] INC0      = INC0_FULL[ACC_W-1:0];

    logic [ACC_W-1:0] tbl_inc [0:7];
    logic [ACC_W-1:0] cust_inc;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] sel_inc;
    logic [OS_W-1:0]  os_cnt;
    logic             restart;
    logic             carry;

    for (genvar g = 0; g < N_RATES; g++) begin : g_tbl
        localparam logic [63:0] INC_FULL = calc_inc(64'(RATE_TABLE[g]), 64'(OSR),
                                                    64'(ACC_W), 64'(CLK_HZ));
        assign tbl_inc[g] = INC_FULL[ACC_W-1:0];
    end

    // A custom write that triggers the restart must apply the new value immediately
    assign tbl_inc[7] = cfg_wr ? cfg_inc : cust_inc;
    assign sel_inc    = tbl_inc[sel];

    assign restart = resync || (sel != active_sel) || (cfg_wr && (sel == SEL_CUSTOM));

    baud_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (restart),
        .inc   (inc_q),
        .carry (carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cust_inc   <= INC0;
            inc_q      <= INC0;
            active_sel <= 3'd0;
            rate_err   <= 1'b0;
            os_cnt     <= '0;
            tick_os    <= 1'b0;
            tick_bit   <= 1'b0;
        end else begin
            if (cfg_wr) begin
                cust_inc <= cfg_inc;
            end
            if (restart) begin
                active_sel <= sel;
                inc_q      <= sel_inc;
                rate_err   <= (sel_inc == '0);
                os_cnt     <= '0;
                tick_os    <= 1'b0;
                tick_bit   <= 1'b0;
            end else begin
                tick_os  <= en && carry;
                tick_bit <= en && carry && (os_cnt == OS_LAST);
                if (en && carry) begin
                    os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: a per-cycle reference model feeds an expected queue,
// and interval checks compare tick spacing against rates worked out by hand.
module tb_baud_gen_frac;

    localparam int ACC_W = 24;
    localparam int OSR   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       sel = 3'd0;
    logic             cfg_wr = 1'b0;
    logic [ACC_W-1:0] cfg_inc = '0;
    logic             resync = 1'b0;
    logic             tick_os;
    logic             tick_bit;
    logic [2:0]       active_sel;
    logic             rate_err;

    baud_gen_frac #(
        .CLK_HZ (7372800),
        .ACC_W  (ACC_W),
        .OSR    (OSR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sel        (sel),
        .cfg_wr     (cfg_wr),
        .cfg_inc    (cfg_inc),
        .resync     (resync),
        .tick_os    (tick_os),
        .tick_bit   (tick_bit),
        .active_sel (active_sel),
        .rate_err   (rate_err)
    );

    always #5 clk = ~clk;

    // Hand-computed increments for 9600..14400 baud at 7.3728 MHz, 16x, 24-bit phase
    logic [ACC_W-1:0] tbl [0:6] = '{24'd349525, 24'd699051, 24'd1398101, 24'd2097152,
                                    24'd4194304, 24'd8388608, 24'd524288};

    logic [5:0]       exp_q [$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;

    logic [ACC_W-1:0] m_acc = '0;
    logic [ACC_W-1:0] m_inc = 24'd349525;
    logic [ACC_W-1:0] m_cust = 24'd349525;
    logic [2:0]       m_sel = 3'd0;
    logic             m_err = 1'b0;
    int               m_os = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc  = '0;
        m_inc  = 24'd349525;
        m_cust = 24'd349525;
        m_sel  = 3'd0;
        m_err  = 1'b0;
        m_os   = 0;
        exp_q.delete();
    endtask

    // One clock: advance the model on the edge, queue its outputs, then compare #1 later
    task automatic step();
        logic             rs;
        logic [ACC_W-1:0] ninc;
        logic [ACC_W:0]   s;
        logic             to;
        logic             tb;
        logic [5:0]       e;
        @(posedge clk);
        cyc++;
        to   = 1'b0;
        tb   = 1'b0;
        rs   = resync || (sel != m_sel) || (cfg_wr && sel == 3'd7);
        ninc = (sel == 3'd7) ? (cfg_wr ? cfg_inc : m_cust) : tbl[sel];
        if (cfg_wr) m_cust = cfg_inc;
        if (rs) begin
            m_acc = '0;
            m_os  = 0;
            m_sel = sel;
            m_inc = ninc;
            m_err = (ninc == '0);
        end else if (en) begin
            s  = {1'b0, m_acc} + {1'b0, m_inc};
            to = s[ACC_W];
            tb = to && (m_os == OSR - 1);
            if (to) m_os = (m_os == OSR - 1) ? 0 : m_os + 1;
            m_acc = s[ACC_W-1:0];
        end
        exp_q.push_back({m_err, m_sel, tb, to});
        #1;
        e = exp_q.pop_front();
        check("tick_os", tick_os, e[0]);
        check("tick_bit", tick_bit, e[1]);
        check("active_sel", active_sel, e[4:2]);
        check("rate_err", rate_err, e[5]);
    endtask

    // Step until the next tick_os (or tick_bit), reporting its cycle and tick_os seen
    task automatic wait_tick(input bit use_bit, input int budget, output int at, output int n_os);
        at   = -1;
        n_os = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (tick_os === 1'b1) n_os++;
            if ((use_bit ? tick_bit : tick_os) === 1'b1) begin
                at = cyc;
                if (use_bit) check("bit_with_os", tick_os, 1);
                break;
            end
        end
        check("tick_in_budget", (at >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        int r, a, b, n, cnt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tick_os", tick_os, 0);
        check("rst_tick_bit", tick_bit, 0);
        check("rst_active_sel", active_sel, 0);
        check("rst_rate_err", rate_err, 0);
        rst = 1'b1;
        en  = 1'b1;

        // 9600: first tick 49 clocks after restart, 16 ticks span 768 clocks
        resync = 1'b1;
        step();
        resync = 1'b0;
        r = cyc;
        wait_tick(0, 100, a, n);
        check("first_tick_lat_9600", a - r, 49);
        for (int i = 0; i < 16; i++) wait_tick(0, 100, b, n);
        check("os16_span_9600", b - a, 768);

        // 57600: exact 8-clock oversample, 128-clock bit period
        sel = 3'd3;
        step();
        wait_tick(0, 20, a, n);
        wait_tick(0, 20, b, n);
        check("os_period_57600", b - a, 8);
        wait_tick(1, 200, a, n);
        wait_tick(1, 200, b, n);
        check("bit_period_57600", b - a, 128);

        // switch 9600 -> 115200 mid-run
        sel = 3'd0;
        for (int i = 0; i < 100; i++) step();
        sel = 3'd4;
        step();
        check("sw_active_sel", active_sel, 4);
        check("sw_tick_os", tick_os, 0);
        r   = cyc;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tick_bit === 1'b1) cnt++;
        end
        check("no_spurious_bit", cnt, 0);
        wait_tick(0, 20, a, n);
        wait_tick(0, 20, b, n);
        check("os_period_115200", b - a, 4);

        // custom increment 2^23 then 0
        sel     = 3'd7;
        cfg_inc = 24'h800000;
        cfg_wr  = 1'b1;
        step();
        cfg_wr = 1'b0;
        r = cyc;
        wait_tick(0, 10, a, n);
        check("first_tick_custom", a - r, 2);
        wait_tick(0, 10, b, n);
        check("os_period_custom", b - a, 2);
        cfg_inc = '0;
        cfg_wr  = 1'b1;
        step();
        cfg_wr = 1'b0;
        check("rate_err_set", rate_err, 1);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tick_os === 1'b1) cnt++;
        end
        check("no_ticks_zero_inc", cnt, 0);

        // 19200 with a 50-clock pause: 100 enabled clocks, next tick at enabled clock 120
        sel = 3'd1;
        step();
        for (int i = 0; i < 100; i++) step();
        en  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if ((tick_os | tick_bit) === 1'b1) cnt++;
        end
        check("no_ticks_disabled", cnt, 0);
        en = 1'b1;
        r  = cyc;
        wait_tick(0, 40, a, n);
        check("resume_phase", a - r, 20);

        // asynchronous reset between edges while outputs are live
        sel = 3'd4;
        step();
        wait_tick(0, 20, a, n);
        #2;
        rst = 1'b0;
        #1;
        check("async_tick_os", tick_os, 0);
        check("async_active_sel", active_sel, 0);
        check("async_tick_bit", tick_bit, 0);
        model_reset();
        #2;
        rst = 1'b1;
        sel = 3'd7;
        step();
        r = cyc;
        wait_tick(0, 100, a, n);
        check("custom_reset_lat", a - r, 49);

        // resync mid-bit: bit tick lands on the 16th oversample tick
        for (int i = 0; i < 5; i++) wait_tick(0, 100, a, n);
        for (int i = 0; i < 20; i++) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        wait_tick(1, 1000, a, n);
        check("resync_bit_after_16", n, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
